// File: rtl/countdown_timer_if.sv
// Register-side and control-FSM-side signals of the countdown timer.
// The register block/FSM drives through master; the timer itself uses slave.
interface countdown_timer_if #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
);
  logic             load;
  logic [CNT_W-1:0] period;
  logic [PRE_W-1:0] prescale;
  logic             run;
  logic             auto_reload;
  logic             trigger;
  logic             enable;
  logic             complete;
  logic [CNT_W-1:0] count;

  modport master (
    output load, period, prescale, run, auto_reload, trigger,
    input  enable, complete, count
  );

  modport slave (
    input  load, period, prescale, run, auto_reload, trigger,
    output enable, complete, count
  );
endinterface

// File: rtl/countdown_timer.sv
// Programmable prescaled down-counter producing enable/complete for the timer
// control FSM; the FSM's trigger acknowledges expiry and may auto-reload.
module countdown_timer #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  countdown_timer_if.slave   tmr_if
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAUSE   = 2'd1,
    S_RUN     = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_reload;
  logic [PRE_W-1:0] r_pre_cnt;
  logic             r_enable;
  logic             r_complete;
  logic             w_tick;

  // >= rather than == so a prescale lowered mid-count cannot strand the divider
  assign w_tick = (r_pre_cnt >= tmr_if.prescale);

  // State, counters and registered enable/complete, all updated together
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= CNT_ZERO;
      r_reload   <= CNT_ZERO;
      r_pre_cnt  <= PRE_ZERO;
      r_enable   <= 1'b0;
      r_complete <= 1'b0;
    end else if (tmr_if.load) begin
      r_reload   <= tmr_if.period;
      r_count    <= tmr_if.period;
      r_pre_cnt  <= PRE_ZERO;
      r_enable   <= 1'b0;
      r_complete <= 1'b0;
      r_state    <= (tmr_if.period == CNT_ZERO) ? S_IDLE : S_PAUSE;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_enable   <= 1'b0;
          r_complete <= 1'b0;
        end
        S_PAUSE: begin
          if (tmr_if.run) begin
            r_state  <= S_RUN;
            r_enable <= 1'b1;
          end else begin
            r_enable <= 1'b0;
          end
          r_complete <= 1'b0;
        end
        S_RUN: begin
          if (!tmr_if.run) begin
            r_state  <= S_PAUSE;
            r_enable <= 1'b0;
          end else if (w_tick) begin
            r_pre_cnt <= PRE_ZERO;
            if (r_count <= CNT_ONE) begin
              // saturate at zero; the 1->0 step is the expiry
              r_count    <= CNT_ZERO;
              r_state    <= S_EXPIRED;
              r_enable   <= 1'b0;
              r_complete <= 1'b1;
            end else begin
              r_count <= r_count - CNT_ONE;
            end
          end else begin
            r_pre_cnt <= r_pre_cnt + PRE_ONE;
          end
        end
        S_EXPIRED: begin
          if (tmr_if.trigger) begin
            r_complete <= 1'b0;
            if (tmr_if.auto_reload) begin
              r_count  <= r_reload;
              r_state  <= tmr_if.run ? S_RUN : S_PAUSE;
              r_enable <= tmr_if.run;
            end else begin
              r_state  <= S_IDLE;
              r_enable <= 1'b0;
            end
          end else begin
            r_complete <= 1'b1;
            r_enable   <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_count    <= CNT_ZERO;
          r_pre_cnt  <= PRE_ZERO;
          r_enable   <= 1'b0;
          r_complete <= 1'b0;
        end
      endcase
    end
  end

  assign tmr_if.enable   = r_enable;
  assign tmr_if.complete = r_complete;
  assign tmr_if.count    = r_count;

endmodule
